// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: default clocking, frame size
// and the receive FSM state encoding.
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit).
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 9600;
    localparam int DATA_BITS     = 8;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS    = 11;  // start + 8 data + parity + stop
`else
    localparam int FRAME_BITS    = 10;  // start + 8 data + stop
`endif

    // Receive FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops
// reset to 1 so an idle (high) line never looks like a start bit.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Resample the raw line twice to settle metastability
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, mid-bit sampling.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after bit 7).
// uart_flag / rx_err are registered one-cycle pulses; uart_data only
// changes on the cycle uart_flag is high. dbg_state exposes the FSM state.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic                 sclk,
    input  logic                 srst,
    input  logic                 rs232_rx,
    output logic                 uart_flag,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 rx_err,
    output logic [2:0]           dbg_state
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic                 rx_s;
    logic                 rx_d3_q;
    logic                 fall;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [2:0]           idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 flag_q,  flag_d;
    logic                 err_q,   err_d;
    logic                 frame_ok;
`ifdef UART_RX_PARITY_EN
    logic                 par_q,   par_d;
`endif

    uart_rx_sync u_sync (
        .clk_i (sclk),
        .rst_i (srst),
        .d_i   (rs232_rx),
        .q_o   (rx_s)
    );

    // Third flop: delayed copy of the synchronized line for edge detect
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) rx_d3_q <= 1'b1;
        else      rx_d3_q <= rx_s;
    end

    assign fall = rx_d3_q & ~rx_s;

    // A frame is accepted only with a high stop bit (and matching parity)
`ifdef UART_RX_PARITY_EN
    assign frame_ok = rx_s & (par_q == (^shift_q));
`else
    assign frame_ok = rx_s;
`endif

    // Next-state logic for the receive FSM, bit counter and shift register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        flag_d  = 1'b0;
        err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                // Re-check the line at mid start bit; a high line was a glitch
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid stop bit lets a back-to-back start bit be seen
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    flag_d  = frame_ok;
                    err_d   = ~frame_ok;
                    if (frame_ok) data_d = shift_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign uart_flag = flag_q;
    assign uart_data = data_q;
    assign rx_err    = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BIT_CYC = 10. Each transmitted frame pushes its
// outcome (good byte or reject) into exp_q; a per-cycle compare process
// pops it when a pulse appears and tracks what uart_data must hold.
module tb_uart_rx;

  localparam int BIT_CYC = 10;

  logic       sclk = 1'b0;
  logic       srst;
  logic       rs232_rx;
  logic       uart_flag;
  logic [7:0] uart_data;
  logic       rx_err;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int flag_cnt = 0;
  int err_cnt = 0;

  // bit 8 = 1 means a rejected frame is expected, else bits 7:0 are the byte
  logic [8:0] exp_q[$];
  logic [7:0] model_data = 8'h00;

  // clock / reset block
  always #5 sclk = ~sclk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  uart_rx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .sclk      (sclk),
    .srst      (srst),
    .rs232_rx  (rs232_rx),
    .uart_flag (uart_flag),
    .uart_data (uart_data),
    .rx_err    (rx_err),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // driver tasks: all input changes happen 2 time units after a rising edge
  task automatic hold(input logic b, input int n);
    rs232_rx = b;
    repeat (n) begin
      @(posedge sclk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    if (stop_b && !par_flip) exp_q.push_back({1'b0, d});
    else                     exp_q.push_back(9'h100);
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, BIT_CYC);
`endif
    hold(stop_b, BIT_CYC);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge sclk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard: compare outputs against the expected outcomes every cycle
  always @(negedge sclk) begin
    logic [8:0] e;
    if (srst) model_data = 8'h00;
    if (uart_flag) flag_cnt++;
    if (rx_err) err_cnt++;
    if (uart_flag && rx_err) check("flag_and_err_together", 1, 0);
    if (uart_flag || rx_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, uart_flag, rx_err}, 0);
      end else begin
        e = exp_q.pop_front();
        if (e[8]) begin
          check("reject_pulse", {31'd0, rx_err}, 1);
        end else begin
          check("accept_pulse", {31'd0, uart_flag}, 1);
          model_data = e[7:0];
        end
      end
    end
    check("uart_data", {24'd0, uart_data}, {24'd0, model_data});
  end

  initial begin
    int f0;
    int e0;
    srst = 1'b1;
    rs232_rx = 1'b1;
    repeat (4) @(posedge sclk);
    @(negedge sclk);
    check("reset_flag", {31'd0, uart_flag}, 0);
    check("reset_err", {31'd0, rx_err}, 0);
    check("reset_data", {24'd0, uart_data}, 0);
    check("reset_state", {29'd0, dbg_state}, 0);
    @(posedge sclk);
    #2;
    srst = 1'b0;
    hold(1'b1, 20);

    // single byte
    f0 = flag_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    hold(1'b1, 20);
    wait_drain("drain_55");
    check("one_flag_55", flag_cnt - f0, 1);
    check("no_err_55", err_cnt - e0, 0);
    check("data_55", {24'd0, uart_data}, 32'h55);

    // back-to-back frames, zero idle time
    f0 = flag_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    send_frame(8'h56, 1'b1, 1'b0);
    hold(1'b1, 20);
    wait_drain("drain_b2b");
    check("four_flags", flag_cnt - f0, 4);
    check("data_last_b2b", {24'd0, uart_data}, 32'h56);

    // short glitch: enters START, then rejected at mid start bit
    f0 = flag_cnt; e0 = err_cnt;
    hold(1'b0, 3);
    check("glitch_in_start", {29'd0, dbg_state}, 1);
    hold(1'b1, 20);
    check("glitch_idle", {29'd0, dbg_state}, 0);
    check("glitch_no_flag", flag_cnt - f0, 0);
    check("glitch_no_err", err_cnt - e0, 0);

    // bad stop bit
    f0 = flag_cnt; e0 = err_cnt;
    send_frame(8'hAA, 1'b0, 1'b0);
    hold(1'b1, 20);
    wait_drain("drain_aa");
    check("stop_err_once", err_cnt - e0, 1);
    check("stop_no_flag", flag_cnt - f0, 0);
    check("data_kept", {24'd0, uart_data}, 32'h56);

    // reset during bit 4 of 8'hA5, then a fresh frame
    f0 = flag_cnt; e0 = err_cnt;
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) hold(1'(8'hA5 >> i), BIT_CYC);
    hold(1'b0, 3);            // bit 4 of A5 is 0
    srst = 1'b1;
    hold(1'b1, 4);
    srst = 1'b0;
    hold(1'b1, 20);
    check("after_abort_idle", {29'd0, dbg_state}, 0);
    check("after_abort_data", {24'd0, uart_data}, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 20);
    wait_drain("drain_3c");
    check("abort_one_flag", flag_cnt - f0, 1);
    check("abort_no_err", err_cnt - e0, 0);
    check("data_3c", {24'd0, uart_data}, 32'h3C);

`ifdef UART_RX_PARITY_EN
    // 8'h07 has three ones: parity bit 1 is correct, 0 is rejected
    f0 = flag_cnt; e0 = err_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    wait_drain("drain_par_bad");
    check("par_bad_err", err_cnt - e0, 1);
    check("par_bad_data", {24'd0, uart_data}, 32'h3C);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    wait_drain("drain_par_good");
    check("par_good_flag", flag_cnt - f0, 1);
    check("par_good_data", {24'd0, uart_data}, 32'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sclk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate; BIT_CYC = CLK_FREQ/BAUD_RATE (integer divide), HALF_CYC = BIT_CYC/2.
REQ-003 SHALL have port sclk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port srst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rs232_rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-006 SHALL have port uart_flag  output  1  one-cycle pulse, received byte valid.
REQ-007 SHALL have port uart_data  output  8  received byte, held stable from uart_flag until the next uart_flag.
REQ-008 SHALL have port rx_err  output  1  one-cycle pulse, frame rejected (bad stop bit, or parity when enabled).

Function
REQ-009 SHALL pass rs232_rx through a 2-flop synchronizer before any use; a third flop SHALL provide falling-edge detection.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (only when enabled), STOP.
REQ-011 IDLE: on synchronized falling edge -> START, baud counter cleared to 0.
REQ-012 START: at count HALF_CYC-1 sample line; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no flag, no rx_err).
REQ-013 DATA: at each count BIT_CYC-1 sample one bit into bit[n], n = 0..7, counter cleared; after bit 7 -> PARITY or STOP.
REQ-014 STOP: at count BIT_CYC-1 sample line; high and no parity error -> uart_flag pulse; otherwise rx_err pulse; then -> IDLE in the same cycle.
REQ-015 uart_flag/rx_err SHALL be registered and assert exactly one cycle after the stop-bit sample edge; uart_data SHALL update on the same edge uart_flag asserts.
REQ-016 uart_flag and rx_err SHALL never assert in the same cycle; a rejected frame SHALL leave uart_data unchanged.
REQ-017 Baud counter width SHALL be $clog2(BIT_CYC); counter SHALL never exceed BIT_CYC-1.
REQ-018 Falling edges during START/DATA/PARITY/STOP SHALL be ignored; a start bit immediately following the stop sample SHALL be detected (back-to-back frames with zero idle time).
REQ-019 Because sampling occurs at mid-stop-bit, next frame start detection SHALL be possible from the cycle after the STOP -> IDLE transition.

Reset
REQ-020 While srst high: state IDLE, counters 0, synchronizer/edge flops 1, uart_flag 0, uart_data 8'h00, rx_err 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no flag and no rx_err; after release the block SHALL wait for a fresh falling edge.

Configuration
REQ-022 Macro UART_RX_PARITY_EN: when defined, one even-parity bit follows bit 7 (state PARITY, sampled at count BIT_CYC-1); mismatch -> rx_err instead of uart_flag at STOP.
REQ-023 Without UART_RX_PARITY_EN, PARITY state and logic SHALL not exist; frame is 10 bits.

Structure
REQ-024 Shared package uart_pkg SHALL hold the state enumeration, default CLK_FREQ/BAUD_RATE constants and frame bit count.
REQ-025 The synchronizer SHALL be a sub-module uart_rx_sync (2 flops, reset value 1, parameterless).

Verification (bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000, BIT_CYC=10)
REQ-026 Send 8'h55 -> exactly one uart_flag, uart_data=8'h55, rx_err never high.
REQ-027 Send 8'h55,8'h12,8'h34,8'h56 back-to-back zero idle -> four flags, data in order, none lost.
REQ-028 Drive rs232_rx low for 3 cycles then high -> no uart_flag, no rx_err, state returns to IDLE.
REQ-029 Send 8'hAA with stop bit 0 -> one rx_err pulse, no uart_flag, uart_data keeps previous value.
REQ-030 Assert srst during bit 4 of 8'hA5, release, send 8'h3C -> only one flag, data 8'h3C.
REQ-031 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 -> rx_err; with parity bit 1 -> uart_flag, data 8'h07.
